pipeline_control: RTL and testbench
===================================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter STAGES, default 5, meaning total pipeline depth; stage 0=IF, 1=ID, 2=EX, STAGES-1=WB; legal range 5..8.
REQ-002 Parameter RA_W, default 5, meaning register-address width.
REQ-003 Parameter LOAD_READY, default STAGES-1, meaning first stage whose load data is forwardable to EX; legal range 3..STAGES-1.
REQ-004 Parameter FWD_W, default $clog2(STAGES-2), meaning forward-select width.
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset, synchronous and active-high.
REQ-007 id_rs1_i, id_rs2_i  in  RA_W each  source registers of the instruction in ID.
REQ-008 id_rd_i  in  RA_W  destination of the instruction in ID.
REQ-009 id_regwrite_i, id_memread_i, id_branch_i  in  1 each  ID decode flags.
REQ-010 branch_taken_i  in  1  ID-stage branch comparison result, already ANDed with id_branch_i.
REQ-011 ex_busy_i  in  1  multi-cycle EX operation not yet complete.
REQ-012 pc_write_o, ifid_write_o  out  1 each  PC and IF/ID register enables.
REQ-013 ifid_flush_o  out  1  zero the IF/ID instruction.
REQ-014 idex_bubble_o, idex_write_o  out  1 each  insert NOP into ID/EX; ID/EX enable.
REQ-015 exmem_bubble_o  out  1  insert NOP into EX/MEM.
REQ-016 fwd_a_o, fwd_b_o  out  FWD_W each  EX operand select; 0=register file, k=result held in stage 2+k.

Function
REQ-017 Block SHALL keep one tracking entry {valid, regwrite, memread, rd} per stage 2..STAGES-1.
REQ-018 On a normal edge, entry 2 SHALL load the ID flags (valid=1) and each entry s>2 SHALL take entry s-1.
REQ-019 On a bubble edge (load-use or branch stall, no ex_busy_i), entry 2 SHALL load valid=0, regwrite=0, memread=0; later entries shift.
REQ-020 When ex_busy_i=1, entry 2 SHALL hold, entry 3 SHALL load an invalid entry, entries >3 SHALL shift.
REQ-021 Register 0 SHALL never match for stall or forwarding purposes.
REQ-022 Load-use stall SHALL assert when an ID source equals rd of a valid memread entry in stage s with s+1 < LOAD_READY.
REQ-023 Branch stall SHALL assert when id_branch_i=1 and an ID source equals rd of a valid regwrite entry in stages 2..STAGES-2.
REQ-024 stall = load-use OR branch stall; on stall: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, idex_write_o=1.
REQ-025 ex_busy_i=1 SHALL override stall: pc_write_o=0, ifid_write_o=0, idex_write_o=0, idex_bubble_o=0, exmem_bubble_o=1.
REQ-026 ifid_flush_o SHALL equal branch_taken_i AND NOT stall AND NOT ex_busy_i.
REQ-027 Otherwise, pc_write_o=1, ifid_write_o=1, idex_write_o=1, and both bubbles 0.
REQ-028 Forward select SHALL be computed against the EX tracking entry's sources, which the block captures from id_rs1_i and id_rs2_i alongside entry 2.
REQ-029 Forward select SHALL pick the youngest valid regwrite stage s in 3..STAGES-1 with matching rd; a load entry SHALL qualify only if s >= LOAD_READY.
REQ-030 No qualifying match SHALL give select 0.
REQ-031 All stall, flush and forward outputs SHALL be combinational; latency from an input change to the outputs is 0 cycles.

Reset
REQ-032 An edge with rst_i=1 SHALL clear every tracking entry and both captured EX sources to 0.
REQ-033 While rst_i=1, outputs SHALL be: pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1, idex_write_o=1, exmem_bubble_o=1, fwd_*=0.
REQ-034 Reset asserted mid-stall or mid-ex_busy SHALL take priority; the first cycle after release SHALL show no stall.

Structure
REQ-035 Forward-select encodings and stage-index constants SHALL reside in a shared package, pipe_pkg.
REQ-036 One sub-module, pipe_track_entry, SHALL implement a single tracking-entry register with hold and bubble controls, instantiated for stages 2..STAGES-1.

Verification
REQ-037 Load into x5 in EX; ID reads rs1=x5 (STAGES=5) -> exactly one stall cycle, then fwd_a_o=2 (WB) in the next EX.
REQ-038 ALU writes x7 in MEM and older write to x7 in WB; EX reads x7 -> fwd_b_o=1 (youngest wins).
REQ-039 Branch in ID with rs1=x3 and ALU writing x3 in EX -> two stall cycles; then branch_taken_i=1 -> ifid_flush_o=1 for one cycle.
REQ-040 ex_busy_i high for 3 cycles -> pc_write_o=0 and exmem_bubble_o=1 for 3 cycles; the EX entry is unchanged, and 3 invalid entries drain past MEM.
REQ-041 Writes to x0 in MEM and WB with EX reading x0 -> fwd=0 and no stall.
REQ-042 STAGES=7, LOAD_READY=6, load to x9 in MEM (stage 3) with ID reading x9 -> stall asserted; same load at stage 5 -> no stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared stage indices, forward-select encodings and control-mode type for the
// pipeline hazard controller.
package pipe_pkg;

  localparam int STAGE_EX    = 2;
  localparam int STAGE_MEM   = 3;
  localparam int FWD_FROM_RF = 0;

  typedef enum logic [1:0] {
    CTRL_RESET,
    CTRL_BUSY,
    CTRL_STALL,
    CTRL_RUN
  } ctrl_mode_e;

  // Forward code k selects the result held in stage STAGE_EX + k.
  function automatic int fwd_code(input int stage);
    return stage - STAGE_EX;
  endfunction

endpackage

// File: rtl/pipe_track_entry.sv
// One tracking entry {valid, regwrite, memread, rd} for a single pipeline stage,
// with hold (keep contents) and bubble (load an empty entry) controls.
module pipe_track_entry #(
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            hold,
  input  logic            bubble,
  input  logic            valid_next,
  input  logic            regwrite_next,
  input  logic            memread_next,
  input  logic [RA_W-1:0] rd_next,
  output logic            valid,
  output logic            regwrite,
  output logic            memread,
  output logic [RA_W-1:0] rd
);

  logic            valid_reg;
  logic            regwrite_reg;
  logic            memread_reg;
  logic [RA_W-1:0] rd_reg;

  // Hold wins over bubble so a stalled EX entry survives an overlapping stall.
  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      rd_reg       <= '0;
    end else if (!hold) begin
      if (bubble) begin
        valid_reg    <= 1'b0;
        regwrite_reg <= 1'b0;
        memread_reg  <= 1'b0;
        rd_reg       <= '0;
      end else begin
        valid_reg    <= valid_next;
        regwrite_reg <= regwrite_next;
        memread_reg  <= memread_next;
        rd_reg       <= rd_next;
      end
    end
  end

  assign valid    = valid_reg;
  assign regwrite = regwrite_reg;
  assign memread  = memread_reg;
  assign rd       = rd_reg;

endmodule

// File: rtl/pipeline_control.sv
// Hazard controller: tracks destinations in EX..WB, raises load-use and branch
// stalls, handles multi-cycle EX holds and selects EX operand forwarding.
module pipeline_control
  import pipe_pkg::*;
#(
  parameter int STAGES     = 5,
  parameter int RA_W       = 5,
  parameter int LOAD_READY = STAGES - 1,
  parameter int FWD_W      = $clog2(STAGES - 2)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [RA_W-1:0]  id_rs1_i,
  input  logic [RA_W-1:0]  id_rs2_i,
  input  logic [RA_W-1:0]  id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             id_branch_i,
  input  logic             branch_taken_i,
  input  logic             ex_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             idex_write_o,
  output logic             exmem_bubble_o,
  output logic [FWD_W-1:0] fwd_a_o,
  output logic [FWD_W-1:0] fwd_b_o
);

  logic            in_valid    [STAGE_EX:STAGES-1];
  logic            in_regwrite [STAGE_EX:STAGES-1];
  logic            in_memread  [STAGE_EX:STAGES-1];
  logic [RA_W-1:0] in_rd       [STAGE_EX:STAGES-1];
  logic            ent_hold    [STAGE_EX:STAGES-1];
  logic            ent_bubble  [STAGE_EX:STAGES-1];
  logic            ent_valid   [STAGE_EX:STAGES-1];
  logic            ent_regwrite[STAGE_EX:STAGES-1];
  logic            ent_memread [STAGE_EX:STAGES-1];
  logic [RA_W-1:0] ent_rd      [STAGE_EX:STAGES-1];
  logic            id_hit      [STAGE_EX:STAGES-1];
  logic            fwd_hit_a   [STAGE_MEM:STAGES-1];
  logic            fwd_hit_b   [STAGE_MEM:STAGES-1];

  logic [RA_W-1:0] ex_rs1_reg;
  logic [RA_W-1:0] ex_rs2_reg;
  logic            load_use;
  logic            branch_hazard;
  logic            stall;
  logic [FWD_W-1:0] fwd_a_next;
  logic [FWD_W-1:0] fwd_b_next;
  ctrl_mode_e      mode;

  genvar gi;
  generate
    for (gi = STAGE_EX; gi < STAGES; gi++) begin : g_entry
      if (gi == STAGE_EX) begin : g_ex
        assign in_valid[gi]    = 1'b1;
        assign in_regwrite[gi] = id_regwrite_i;
        assign in_memread[gi]  = id_memread_i;
        assign in_rd[gi]       = id_rd_i;
        assign ent_hold[gi]    = ex_busy_i;
        assign ent_bubble[gi]  = stall;
      end else begin : g_shift
        assign in_valid[gi]    = ent_valid[gi-1];
        assign in_regwrite[gi] = ent_regwrite[gi-1];
        assign in_memread[gi]  = ent_memread[gi-1];
        assign in_rd[gi]       = ent_rd[gi-1];
        assign ent_hold[gi]    = 1'b0;
        // MEM receives an empty slot each cycle EX is held, draining older work.
        assign ent_bubble[gi]  = (gi == STAGE_MEM) ? ex_busy_i : 1'b0;

        // Loads only forward once their data exists.
        assign fwd_hit_a[gi] = ent_valid[gi] && ent_regwrite[gi] &&
                               (!ent_memread[gi] || (gi >= LOAD_READY)) &&
                               (ent_rd[gi] != '0) && (ent_rd[gi] == ex_rs1_reg);
        assign fwd_hit_b[gi] = ent_valid[gi] && ent_regwrite[gi] &&
                               (!ent_memread[gi] || (gi >= LOAD_READY)) &&
                               (ent_rd[gi] != '0) && (ent_rd[gi] == ex_rs2_reg);
      end

      assign id_hit[gi] = (ent_rd[gi] != '0) &&
                          ((ent_rd[gi] == id_rs1_i) || (ent_rd[gi] == id_rs2_i));

      pipe_track_entry #(
        .RA_W(RA_W)
      ) u_entry (
        .clk           (clk_i),
        .srst          (rst_i),
        .hold          (ent_hold[gi]),
        .bubble        (ent_bubble[gi]),
        .valid_next    (in_valid[gi]),
        .regwrite_next (in_regwrite[gi]),
        .memread_next  (in_memread[gi]),
        .rd_next       (in_rd[gi]),
        .valid         (ent_valid[gi]),
        .regwrite      (ent_regwrite[gi]),
        .memread       (ent_memread[gi]),
        .rd            (ent_rd[gi])
      );
    end
  endgenerate

  // EX sources travel with entry 2: held while busy, emptied on a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_rs1_reg <= '0;
      ex_rs2_reg <= '0;
    end else if (!ex_busy_i) begin
      if (stall) begin
        ex_rs1_reg <= '0;
        ex_rs2_reg <= '0;
      end else begin
        ex_rs1_reg <= id_rs1_i;
        ex_rs2_reg <= id_rs2_i;
      end
    end
  end

  always_comb begin
    load_use      = 1'b0;
    branch_hazard = 1'b0;
    for (int s = STAGE_EX; s < STAGES; s++) begin
      if ((s + 1 < LOAD_READY) && ent_valid[s] && ent_memread[s] && id_hit[s])
        load_use = 1'b1;
      if ((s <= STAGES - 2) && ent_valid[s] && ent_regwrite[s] && id_hit[s] && id_branch_i)
        branch_hazard = 1'b1;
    end
  end

  assign stall = load_use | branch_hazard;

  // Walk oldest to youngest so the youngest qualifying producer wins.
  always_comb begin
    fwd_a_next = FWD_W'(FWD_FROM_RF);
    fwd_b_next = FWD_W'(FWD_FROM_RF);
    for (int s = STAGES - 1; s >= STAGE_MEM; s--) begin
      if (fwd_hit_a[s]) fwd_a_next = FWD_W'(fwd_code(s));
      if (fwd_hit_b[s]) fwd_b_next = FWD_W'(fwd_code(s));
    end
  end

  always_comb begin
    if (rst_i)          mode = CTRL_RESET;
    else if (ex_busy_i) mode = CTRL_BUSY;
    else if (stall)     mode = CTRL_STALL;
    else                mode = CTRL_RUN;
  end

  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    idex_write_o   = 1'b1;
    exmem_bubble_o = 1'b0;
    fwd_a_o        = fwd_a_next;
    fwd_b_o        = fwd_b_next;
    case (mode)
      CTRL_RESET: begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        ifid_flush_o   = 1'b1;
        idex_bubble_o  = 1'b1;
        exmem_bubble_o = 1'b1;
        fwd_a_o        = FWD_W'(FWD_FROM_RF);
        fwd_b_o        = FWD_W'(FWD_FROM_RF);
      end
      CTRL_BUSY: begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        idex_write_o   = 1'b0;
        exmem_bubble_o = 1'b1;
      end
      CTRL_STALL: begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end
      default: begin
        ifid_flush_o = branch_taken_i;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: a default 5-stage instance plus a
// 7-stage instance with LOAD_READY=6.
module tb_pipeline_control;

  localparam logic [5:0] C_RUN   = 6'b110010;
  localparam logic [5:0] C_RUNFL = 6'b111010;
  localparam logic [5:0] C_STALL = 6'b000110;
  localparam logic [5:0] C_BUSY  = 6'b000001;
  localparam logic [5:0] C_RST   = 6'b001111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: STAGES=5
  logic [4:0] a_rs1 = '0, a_rs2 = '0, a_rd = '0;
  logic a_rw = 1'b0, a_mr = 1'b0, a_br = 1'b0, a_tk = 1'b0, a_busy = 1'b0;
  logic a_pcw, a_ifw, a_fl, a_ib, a_iw, a_eb;
  logic [1:0] a_fa, a_fb;
  logic [5:0] a_ctrl;
  assign a_ctrl = {a_pcw, a_ifw, a_fl, a_ib, a_iw, a_eb};

  pipeline_control #(.STAGES(5)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(a_rs1), .id_rs2_i(a_rs2), .id_rd_i(a_rd),
    .id_regwrite_i(a_rw), .id_memread_i(a_mr), .id_branch_i(a_br),
    .branch_taken_i(a_tk), .ex_busy_i(a_busy),
    .pc_write_o(a_pcw), .ifid_write_o(a_ifw), .ifid_flush_o(a_fl),
    .idex_bubble_o(a_ib), .idex_write_o(a_iw), .exmem_bubble_o(a_eb),
    .fwd_a_o(a_fa), .fwd_b_o(a_fb)
  );

  // Instance B: STAGES=7, LOAD_READY=6
  logic [4:0] b_rs1 = '0, b_rs2 = '0, b_rd = '0;
  logic b_rw = 1'b0, b_mr = 1'b0, b_br = 1'b0, b_tk = 1'b0, b_busy = 1'b0;
  logic b_pcw, b_ifw, b_fl, b_ib, b_iw, b_eb;
  logic [2:0] b_fa, b_fb;
  logic [5:0] b_ctrl;
  assign b_ctrl = {b_pcw, b_ifw, b_fl, b_ib, b_iw, b_eb};

  pipeline_control #(.STAGES(7), .LOAD_READY(6)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(b_rs1), .id_rs2_i(b_rs2), .id_rd_i(b_rd),
    .id_regwrite_i(b_rw), .id_memread_i(b_mr), .id_branch_i(b_br),
    .branch_taken_i(b_tk), .ex_busy_i(b_busy),
    .pc_write_o(b_pcw), .ifid_write_o(b_ifw), .ifid_flush_o(b_fl),
    .idex_bubble_o(b_ib), .idex_write_o(b_iw), .exmem_bubble_o(b_eb),
    .fwd_a_o(b_fa), .fwd_b_o(b_fb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_a(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br);
    a_rs1 = rs1; a_rs2 = rs2; a_rd = rd; a_rw = rw; a_mr = mr; a_br = br;
  endtask

  task automatic set_b(input logic [4:0] rs1, input logic [4:0] rd,
                       input logic rw, input logic mr);
    b_rs1 = rs1; b_rs2 = '0; b_rd = rd; b_rw = rw; b_mr = mr; b_br = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst = 1'b1;
    a_tk = 1'b1;
    tick(); tick();
    chk("rst_ctrl", 8'(a_ctrl), 8'(C_RST));
    chk("rst_fwd_a", 8'(a_fa), 8'd0);
    chk("rst_fwd_b", 8'(a_fb), 8'd0);
    chk("rst_ctrl_b", 8'(b_ctrl), 8'(C_RST));
    a_tk = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_run", 8'(a_ctrl), 8'(C_RUN));

    // Load-use on x5: one stall, then forward from WB
    set_a(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    set_a(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("loaduse_stall", 8'(a_ctrl), 8'(C_STALL));
    tick();
    chk("loaduse_released", 8'(a_ctrl), 8'(C_RUN));
    tick();
    set_a(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("loaduse_fwd_a_wb", 8'(a_fa), 8'd2);
    chk("loaduse_fwd_b_rf", 8'(a_fb), 8'd0);

    // Two writers of x7: youngest (MEM) wins
    set_a(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    set_a(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    set_a(5'd0, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    set_a(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("youngest_fwd_b", 8'(a_fb), 8'd1);
    chk("youngest_fwd_a", 8'(a_fa), 8'd0);

    // Writes to x0 never match
    set_a(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    set_a(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("x0_no_stall", 8'(a_ctrl), 8'(C_RUN));
    tick();
    tick();
    #1;
    chk("x0_fwd_a", 8'(a_fa), 8'd0);
    chk("x0_fwd_b", 8'(a_fb), 8'd0);

    // Branch on x3 behind ALU write of x3: two stalls, then flush
    set_a(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    set_a(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("branch_stall_1", 8'(a_ctrl), 8'(C_STALL));
    tick();
    a_tk = 1'b1;
    #1;
    chk("branch_stall_2", 8'(a_ctrl), 8'(C_STALL));
    tick();
    chk("branch_flush", 8'(a_ctrl), 8'(C_RUNFL));
    tick();
    a_tk = 1'b0;
    set_a(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("branch_flush_done", 8'(a_ctrl), 8'(C_RUN));

    // ex_busy for 3 cycles: EX entry held, empties drain past MEM
    set_a(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    set_a(5'd7, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    set_a(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("busy_pre_fwd_a", 8'(a_fa), 8'd1);
    a_busy = 1'b1;
    #1;
    chk("busy_ctrl_1", 8'(a_ctrl), 8'(C_BUSY));
    tick();
    chk("busy_ctrl_2", 8'(a_ctrl), 8'(C_BUSY));
    chk("busy_fwd_a_wb", 8'(a_fa), 8'd2);
    tick();
    chk("busy_ctrl_3", 8'(a_ctrl), 8'(C_BUSY));
    chk("busy_fwd_a_drained", 8'(a_fa), 8'd0);
    tick();
    a_busy = 1'b0;
    set_a(5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
    #1;
    chk("busy_released", 8'(a_ctrl), 8'(C_RUN));
    chk("busy_mem_empty", 8'(a_fa), 8'd0);
    tick();
    set_a(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("busy_ex_entry_kept", 8'(a_fa), 8'd1);

    // Reset mid-stall and mid-busy takes priority
    set_a(5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0);
    tick();
    set_a(5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("pre_rst_stall", 8'(a_ctrl), 8'(C_STALL));
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", 8'(a_ctrl), 8'(C_RST));
    a_busy = 1'b1;
    #1;
    chk("rst_mid_busy", 8'(a_ctrl), 8'(C_RST));
    tick();
    rst = 1'b0;
    a_busy = 1'b0;
    #1;
    chk("rst_release_no_stall", 8'(a_ctrl), 8'(C_RUN));

    // STAGES=7, LOAD_READY=6: load to x9 stalls at stages 3,4, not 5
    set_b(5'd0, 5'd9, 1'b1, 1'b1);
    tick();
    set_b(5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    set_b(5'd9, 5'd1, 1'b1, 1'b0);
    #1;
    chk("b_stall_stage3", 8'(b_ctrl), 8'(C_STALL));
    tick();
    chk("b_stall_stage4", 8'(b_ctrl), 8'(C_STALL));
    tick();
    chk("b_no_stall_stage5", 8'(b_ctrl), 8'(C_RUN));
    tick();
    set_b(5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("b_fwd_a_stage6", 8'(b_fa), 8'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
